// File: rtl/elevator_motion_door_ctrl.sv
// Motion and door controller for a six-stop elevator car: tracks the one-hot car
// position, drives the Up/Down travel indicators and the door, and strobes request clears.
module elevator_motion_door_ctrl #(
    parameter int NUM_FLOORS  = 6,
    parameter int MOVE_CYCLES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [NUM_FLOORS-1:0] inputfloors,
    input  logic                  close_btn,
    output logic [NUM_FLOORS-1:0] currentFloor,
    output logic                  Up,
    output logic                  Down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] closeDoor
);

    localparam int CW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam logic [NUM_FLOORS-1:0] FLOOR_ONE = NUM_FLOORS'(1);
    localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]         CNT_LAST  = CW'(MOVE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_last_up;
    logic [CW-1:0]   r_cnt;

    logic [NUM_FLOORS-1:0] w_above_mask;
    logic [NUM_FLOORS-1:0] w_below_mask;
    logic                  w_req_here;
    logic                  w_req_above;
    logic                  w_req_below;
    logic                  w_go_up;
    logic                  w_go_down;

    // For a one-hot position p, p-1 covers every stop below it and its complement
    // shifted once covers every stop above; at the top floor the above mask is empty.
    assign w_below_mask = currentFloor - FLOOR_ONE;
    assign w_above_mask = ~((currentFloor << 1) - FLOOR_ONE);
    assign w_req_here   = |(inputfloors & currentFloor);
    assign w_req_above  = |(inputfloors & w_above_mask);
    assign w_req_below  = |(inputfloors & w_below_mask);
    assign w_go_up      = w_req_above & (r_last_up | ~w_req_below);
    assign w_go_down    = w_req_below & (~r_last_up | ~w_req_above);

    assign closeDoor = {NUM_FLOORS{close_btn}} & currentFloor;

    // Car state machine with registered position, direction and door outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state      <= ST_IDLE;
            currentFloor <= FLOOR_ONE;
            Up           <= 1'b0;
            Down         <= 1'b0;
            door_open    <= 1'b0;
            r_last_up    <= 1'b1;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_req_here) begin
                        r_state   <= ST_DOOR_OPEN;
                        door_open <= 1'b1;
                    end else if (w_go_up) begin
                        r_state   <= ST_MOVE_UP;
                        Up        <= 1'b1;
                        r_last_up <= 1'b1;
                    end else if (w_go_down) begin
                        r_state   <= ST_MOVE_DOWN;
                        Down      <= 1'b1;
                        r_last_up <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MOVE_UP: begin
                    // Arrival is judged on the registered position, one cycle after the step
                    if (w_req_here) begin
                        r_state   <= ST_DOOR_OPEN;
                        Up        <= 1'b0;
                        door_open <= 1'b1;
                        r_cnt     <= '0;
                    end else if (!w_req_above) begin
                        r_state <= ST_IDLE;
                        Up      <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        currentFloor <= currentFloor << 1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_MOVE_DOWN: begin
                    if (w_req_here) begin
                        r_state   <= ST_DOOR_OPEN;
                        Down      <= 1'b0;
                        door_open <= 1'b1;
                        r_cnt     <= '0;
                    end else if (!w_req_below) begin
                        r_state <= ST_IDLE;
                        Down    <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        currentFloor <= currentFloor >> 1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_DOOR_OPEN: begin
                    if (close_btn) begin
                        r_state   <= ST_IDLE;
                        door_open <= 1'b0;
                    end else begin
                        r_state <= ST_DOOR_OPEN;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    Up        <= 1'b0;
                    Down      <= 1'b0;
                    door_open <= 1'b0;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_motion_door_ctrl.sv
// Directed self-checking bench for elevator_motion_door_ctrl with hand-computed expectations.
module tb_elevator_motion_door_ctrl;

    logic       Clock;
    logic       Reset;
    logic [5:0] inputfloors;
    logic       close_btn;
    logic [5:0] currentFloor;
    logic       Up;
    logic       Down;
    logic       door_open;
    logic [5:0] closeDoor;

    int checks = 0;
    int errors = 0;

    elevator_motion_door_ctrl #(.NUM_FLOORS(6), .MOVE_CYCLES(1)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .inputfloors (inputfloors),
        .close_btn   (close_btn),
        .currentFloor(currentFloor),
        .Up          (Up),
        .Down        (Down),
        .door_open   (door_open),
        .closeDoor   (closeDoor)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] cf, input logic up,
                           input logic dn, input logic dr);
        chk6({tag, "_floor"}, currentFloor, cf);
        chk1({tag, "_up"}, Up, up);
        chk1({tag, "_down"}, Down, dn);
        chk1({tag, "_door"}, door_open, dr);
    endtask

    initial begin
        Reset       = 1'b0;
        inputfloors = 6'b000000;
        close_btn   = 1'b0;

        // 1. reset
        repeat (2) @(negedge Clock);
        chk_all("reset", 6'b000001, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        @(negedge Clock);
        chk_all("post_reset", 6'b000001, 1'b0, 1'b0, 1'b0);

        // 2. request two stops up
        inputfloors = 6'b000100;
        @(negedge Clock);
        chk_all("t2_start", 6'b000001, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t2_step1", 6'b000010, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t2_step2", 6'b000100, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t2_arrive", 6'b000100, 1'b0, 1'b0, 1'b1);
        @(negedge Clock);
        chk_all("t2_hold", 6'b000100, 1'b0, 1'b0, 1'b1);
        chk6("t2_no_clear", closeDoor, 6'b000000);

        // 3. close pulse
        close_btn = 1'b1;
        #1;
        chk6("t3_clear_strobe", closeDoor, 6'b000100);
        inputfloors = 6'b000000;
        @(negedge Clock);
        close_btn = 1'b0;
        chk_all("t3_closed", 6'b000100, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t3_idle", 6'b000100, 1'b0, 1'b0, 1'b0);

        // 4. requests both ways: keep going up first, then reverse
        inputfloors = 6'b100001;
        @(negedge Clock);
        chk_all("t4_up_start", 6'b000100, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t4_up1", 6'b001000, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t4_up2", 6'b010000, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t4_up3", 6'b100000, 1'b1, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t4_top_door", 6'b100000, 1'b0, 1'b0, 1'b1);
        close_btn = 1'b1;
        #1;
        chk6("t4_top_clear", closeDoor, 6'b100000);
        inputfloors = 6'b000001;
        @(negedge Clock);
        close_btn = 1'b0;
        chk_all("t4_top_closed", 6'b100000, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        chk_all("t4_down_start", 6'b100000, 1'b0, 1'b1, 1'b0);
        @(negedge Clock);
        chk_all("t4_dn1", 6'b010000, 1'b0, 1'b1, 1'b0);
        @(negedge Clock);
        chk_all("t4_dn2", 6'b001000, 1'b0, 1'b1, 1'b0);
        @(negedge Clock);
        chk_all("t4_dn3", 6'b000100, 1'b0, 1'b1, 1'b0);
        @(negedge Clock);
        chk_all("t4_dn4", 6'b000010, 1'b0, 1'b1, 1'b0);
        @(negedge Clock);
        chk_all("t4_dn5", 6'b000001, 1'b0, 1'b1, 1'b0);
        @(negedge Clock);
        chk_all("t4_bottom_door", 6'b000001, 1'b0, 1'b0, 1'b1);
        close_btn   = 1'b1;
        inputfloors = 6'b000000;
        @(negedge Clock);
        close_btn = 1'b0;
        chk_all("t4_bottom_closed", 6'b000001, 1'b0, 1'b0, 1'b0);

        // 5. request at the current stop opens the door without moving
        inputfloors = 6'b000001;
        @(negedge Clock);
        chk_all("t5_open_here", 6'b000001, 1'b0, 1'b0, 1'b1);
        close_btn   = 1'b1;
        inputfloors = 6'b000000;
        @(negedge Clock);
        close_btn = 1'b0;
        chk_all("t5_closed", 6'b000001, 1'b0, 1'b0, 1'b0);

        // 6. asynchronous reset mid-travel
        inputfloors = 6'b010000;
        @(negedge Clock);
        chk_all("t6_start", 6'b000001, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge Clock);
        chk_all("t6_at_f3", 6'b001000, 1'b1, 1'b0, 1'b0);
        #2;
        Reset = 1'b0;
        #1;
        chk_all("t6_async_reset", 6'b000001, 1'b0, 1'b0, 1'b0);
        inputfloors = 6'b000000;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        chk_all("t6_after_release", 6'b000001, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
